// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus per-bit stability filter with registered edge pulses.
module switch_debouncer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW_IN,
  output logic [WIDTH-1:0] SW_OUT,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             CHANGED
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1_q, s2_q, out_q, out_d, rise_q, rise_d, fall_q, fall_d, fire;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  // The counter clears on agreement or on firing, so it can never reach a wrap.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    assign fire[i]  = (s2_q[i] ^ out_q[i]) && cnt_q[i] == CNT_MAX;
    assign cnt_d[i] = (s2_q[i] == out_q[i] || fire[i]) ? '0 : cnt_q[i] + CNT_W'(1);
  end
  always_comb begin
    out_d  = out_q ^ fire;
    rise_d = fire & s2_q;
    fall_d = fire & ~s2_q;
    chg_d  = |fire;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q   <= '0;
      s2_q   <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
      cnt_q  <= '{default: '0};
    end else begin
      s1_q   <= SW_IN;
      s2_q   <= s1_q;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end
  assign SW_OUT  = out_q;
  assign SW_RISE = rise_q;
  assign SW_FALL = fall_q;
  assign CHANGED = chg_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed stimulus checked against a sliding-window model of the debouncer.
module tb_switch_debouncer;
  localparam int W  = 16;
  localparam int DC = 4;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] SW_IN = '0;
  logic [W-1:0] SW_OUT, SW_RISE, SW_FALL;
  logic         CHANGED;
  int checks = 0, errors = 0;
  int rise3_cnt = 0, fall_cnt = 0, chg_cnt = 0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .CLK(CLK), .RST(RST), .SW_IN(SW_IN),
    .SW_OUT(SW_OUT), .SW_RISE(SW_RISE), .SW_FALL(SW_FALL), .CHANGED(CHANGED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Model: a bit flips when the last DC synchronised samples (the input two edges ago and older) all differ from it.
  logic [W-1:0] hist [DC+1];
  logic [W-1:0] m_out, m_rise, m_fall, m_fire;
  logic         m_chg;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k <= DC; k++) hist[k] = '0;
      m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
    end else begin
      m_fire = '1;
      for (int k = 1; k <= DC; k++) m_fire &= hist[k] ^ m_out;
      m_rise = m_fire & ~m_out;
      m_fall = m_fire & m_out;
      m_out  = m_out ^ m_fire;
      m_chg  = |m_fire;
      for (int k = DC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = SW_IN;
    end
  end

  always @(negedge CLK) begin
    chk("sw_out", SW_OUT, m_out);
    chk("sw_rise", SW_RISE, m_rise);
    chk("sw_fall", SW_FALL, m_fall);
    chk("changed", {{(W-1){1'b0}}, CHANGED}, {{(W-1){1'b0}}, m_chg});
    chk("rise_fall_excl", SW_RISE & SW_FALL, '0);
    if (SW_RISE[3]) rise3_cnt++;
    if (|SW_FALL) fall_cnt++;
    if (CHANGED) chg_cnt++;
  end

  initial begin
    step(2);
    RST = 1'b0;
    step(20);
    chk("idle_out", SW_OUT, '0);
    chk("idle_pulses", 16'(chg_cnt), 16'd0);
    SW_IN = 16'h0008;
    step(5);
    chk("single_pre", SW_OUT, 16'h0000);
    step(1);
    chk("single_out", SW_OUT, 16'h0008);
    chk("single_rise", SW_RISE, 16'h0008);
    chk("single_chg", {15'b0, CHANGED}, 16'd1);
    step(1);
    chk("single_rise_off", SW_RISE, 16'h0000);
    chk("single_chg_off", {15'b0, CHANGED}, 16'd0);
    SW_IN = 16'h0000;
    step(10);
    chk("single_fall_done", SW_OUT, 16'h0000);
    rise3_cnt = 0;
    SW_IN = 16'h0008; step(1);
    SW_IN = 16'h0000; step(1);
    SW_IN = 16'h0008; step(1);
    SW_IN = 16'h0000; step(1);
    SW_IN = 16'h0008;
    step(5);
    chk("bounce_pre", SW_OUT, 16'h0000);
    step(1);
    chk("bounce_out", SW_OUT, 16'h0008);
    step(10);
    chk("bounce_rise_cnt", 16'(rise3_cnt), 16'd1);
    SW_IN = 16'h0000;
    step(10);
    chg_cnt = 0;
    SW_IN = 16'hA5F0;
    step(6);
    chk("multi_out", SW_OUT, 16'hA5F0);
    chk("multi_rise", SW_RISE, 16'hA5F0);
    chk("multi_chg", {15'b0, CHANGED}, 16'd1);
    step(10);
    chk("multi_chg_cnt", 16'(chg_cnt), 16'd1);
    SW_IN = 16'h0000;
    step(6);
    chk("multi_fall", SW_FALL, 16'hA5F0);
    chk("multi_out0", SW_OUT, 16'h0000);
    SW_IN = 16'hFFFF;
    step(10);
    chk("all_out", SW_OUT, 16'hFFFF);
    fall_cnt = 0;
    SW_IN = 16'h7FFF;
    step(3);
    SW_IN = 16'hFFFF;
    step(10);
    chk("glitch_out", SW_OUT, 16'hFFFF);
    chk("glitch_fall_cnt", 16'(fall_cnt), 16'd0);
    SW_IN = 16'h8000;
    step(10);
    chk("prerst_out", SW_OUT, 16'h8000);
    SW_IN = 16'h8001;
    step(3);
    #2 RST = 1'b1;
    #1;
    chk("rst_out", SW_OUT, 16'h0000);
    chk("rst_rise", SW_RISE, 16'h0000);
    step(1);
    RST = 1'b0;
    step(5);
    chk("rerun_pre", SW_OUT, 16'h0000);
    step(1);
    chk("rerun_out", SW_OUT, 16'h8001);
    chk("rerun_rise", SW_RISE, 16'h8001);
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-conditioning stage between the board slide switches and every consumer of switch state: the RGB LED controller colour fields and the seven-segment hex encoding.
- Per bit: synchronises raw asynchronous switch inputs into the CLK domain, filters mechanical bounce with a stability counter, and presents clean levels plus one-cycle edge pulses.
- Replaces direct use of raw SW in the top level.

Parameters:
- WIDTH, 16, number of switch bits handled (one independent channel per bit).
- DEBOUNCE_CYCLES, 1000000, consecutive CLK cycles a synchronised input must differ from the output before the output follows (10 ms at 100 MHz); legal range 2 .. 2^24.
- CNT_W, $clog2(DEBOUNCE_CYCLES), stability counter width; derived, not overridden.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- SW_IN  input  WIDTH  raw switch levels, asynchronous to CLK.
- SW_OUT  output  WIDTH  debounced, registered switch levels.
- SW_RISE  output  WIDTH  one-cycle pulse per bit when SW_OUT[i] goes 0->1.
- SW_FALL  output  WIDTH  one-cycle pulse per bit when SW_OUT[i] goes 1->0.
- CHANGED  output  1  one-cycle pulse when any SW_OUT bit changed this cycle (OR of SW_RISE and SW_FALL).

Behaviour:
- Reset (asynchronous, RST=1):
  - sync stage 1 and 2 registers, all counters, SW_OUT, SW_RISE, SW_FALL and CHANGED clear to 0 immediately.
  - No pulses are generated on reset assertion or release.
- Synchronisation: two-flop chain per bit (s1 <= SW_IN, s2 <= s1). Only s2 is used downstream.
- Per-bit filter, evaluated each edge:
  - If s2[i] == SW_OUT[i]: cnt[i] <= 0; no pulse.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1:
    - SW_OUT[i] <= s2[i] and cnt[i] <= 0.
    - SW_RISE[i] <= s2[i] and SW_FALL[i] <= ~s2[i], both for exactly one cycle.
  - Else: cnt[i] <= cnt[i]+1.
- Glitch handling: any cycle where s2 returns to SW_OUT clears cnt; a partial count is never retained.
- Latency:
  - Call the edge that first samples the new SW_IN value edge 1.
  - SW_OUT changes on edge DEBOUNCE_CYCLES+2, provided SW_IN is held stable throughout.
  - SW_RISE/SW_FALL/CHANGED assert in the same cycle SW_OUT changes.
- Pulses:
  - SW_RISE, SW_FALL and CHANGED are registered and default to 0 every cycle unless set by the rule above.
  - SW_RISE[i] and SW_FALL[i] are never both 1.
  - SW_OUT[i] cannot change again for at least DEBOUNCE_CYCLES cycles after a change, so back-to-back pulses on the same bit are impossible.
- Channels are independent:
  - Simultaneous transitions on several bits produce simultaneous pulses and a single CHANGED cycle.
  - Staggered transitions produce separate CHANGED pulses.
- Counter never wraps: it saturates logically because it is reset at DEBOUNCE_CYCLES-1.
- Reset mid-count: all counters are discarded. After release, SW_OUT starts from 0 and a held-high input re-qualifies with the full latency and produces a rise pulse.

Test Plan:
- Bench with DEBOUNCE_CYCLES=4, WIDTH=16.
- Reset, SW_IN=16'h0000 -> SW_OUT=0, no SW_RISE, SW_FALL or CHANGED pulses for 20 cycles.
- SW_IN[3] 0->1 held -> SW_OUT[3]=1 on edge 6 after sampling; SW_RISE[3] and CHANGED high exactly that one cycle; all other bits stay 0.
- SW_IN[3] bounces 1,0,1,0 (1 cycle each), then held at 1 -> no SW_OUT change during the bounce; SW_OUT[3] rises 6 edges after the last 0->1 sampling edge; exactly one SW_RISE[3] pulse.
- SW_IN 16'h0000 -> 16'hA5F0 in one cycle -> SW_OUT=16'hA5F0 on a single edge; SW_RISE=16'hA5F0; single CHANGED pulse. Return to 0 -> SW_FALL=16'hA5F0.
- SW_IN=16'hFFFF stable, SW_OUT reaches 16'hFFFF, then SW_IN[15]=0 for 3 cycles only -> SW_OUT stays 16'hFFFF, no SW_FALL pulse.
- SW_IN[0]=1 with count mid-way (after 2 cycles), assert RST asynchronously between edges -> outputs clear immediately. After release with SW_IN[0] still 1 -> full 6-edge latency, one SW_RISE[0] pulse.
